// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: zero/sign/upper/branch conversion behind a
// valid/ready interface with a 2-entry (output + skid) buffer and flush.
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  // Branch mode needs two spare bits above the immediate for the <<2.
  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
  end

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;

  // Encoding chosen so bit 0 is out_valid and bit 1 is skid_valid.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [OUT_W-1:0] skid_data;
  logic [1:0]       skid_mode;
  logic [OUT_W-1:0] conv_c;
  logic [OUT_W-1:0] sext_c;
  logic             drain_c;
  logic             accept_c;
  logic             load_out_in;
  logic             load_out_skid;
  logic             load_skid;

  assign out_valid = state[0];
  assign in_ready  = ~state[1];
  assign drain_c   = ~state[0] | out_ready;
  assign accept_c  = in_valid & ~state[1];

  // Immediate conversion for the word presented this cycle.
  always_comb begin
    sext_c = OUT_W'($signed(in_imm));
    conv_c = '0;
    case (in_mode)
      MODE_ZERO:  conv_c = OUT_W'(in_imm);
      MODE_SIGN:  conv_c = sext_c;
      MODE_UPPER: conv_c = OUT_W'(in_imm) << EXT_W;
      default:    conv_c = sext_c << 2;
    endcase
  end

  // Next-state and register load selects.
  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept_c) begin
          state_nxt   = S_ONE;
          load_out_in = 1'b1;
        end
      end
      S_ONE: begin
        if (drain_c) begin
          if (accept_c) begin
            load_out_in = 1'b1;
          end else begin
            state_nxt = S_EMPTY;
          end
        end else if (accept_c) begin
          state_nxt = S_FULL;
          load_skid = 1'b1;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          state_nxt     = S_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // State register; flush clears the valids but leaves data stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output and skid payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_mode  <= MODE_ZERO;
      skid_data <= '0;
      skid_mode <= MODE_ZERO;
    end else if (!flush) begin
      if (load_out_skid) begin
        out_data <= skid_data;
        out_mode <= skid_mode;
      end else if (load_out_in) begin
        out_data <= conv_c;
        out_mode <= in_mode;
      end
      if (load_skid) begin
        skid_data <= conv_c;
        skid_mode <= in_mode;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: modes, back-pressure, streaming, flush,
// reset mid-stall and a narrow 8->16 instance.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_imm8;
  logic [1:0]  in_mode8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] out_data8;
  logic [1:0]  out_mode8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_imm(in_imm8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_mode(out_mode8)
  );

  // Reference conversion for the 16->32 instance.
  function automatic logic [31:0] ref32(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] s;
    s = imm[15] ? (32'hFFFF0000 | {16'h0000, imm}) : {16'h0000, imm};
    case (mode)
      2'd0:    return {16'h0000, imm};
      2'd1:    return s;
      2'd2:    return {imm, 16'h0000};
      default: return s * 32'd4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_valids: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_cmp++;
    if (out_data !== 32'h0 || out_mode !== 2'b00) begin
      n_err++;
      $display("FAIL reset_data: out_data=%h out_mode=%b want 0/00", out_data, out_mode);
    end
  endtask

  task automatic test_modes();
    logic [31:0] exp [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 16'h8001, 2'(m));
      tick();
      drive(1'b0, 16'h0, 2'b00);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp[m] || out_mode !== 2'(m)) begin
        n_err++;
        $display("FAIL mode%0d: valid=%b data=%h mode=%b want 1/%h/%0d",
                 m, out_valid, out_data, out_mode, exp[m], m);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mode%0d_once: out_valid=%b want 0", m, out_valid);
      end
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'b01);
    tick();
    drive(1'b1, 16'h0002, 2'b01);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    drive(1'b1, 16'h0003, 2'b01);
    n_cmp++;
    if (in_ready !== 1'b0 || out_data !== 32'h1) begin
      n_err++;
      $display("FAIL bp_full: in_ready=%b data=%h want 0/00000001", in_ready, out_data);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1) begin
      n_err++;
      $display("FAIL bp_hold: in_ready=%b valid=%b data=%h want 0/1/00000001",
               in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h2 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_skid_out: valid=%b data=%h in_ready=%b want 1/00000002/1",
               out_valid, out_data, in_ready);
    end
    tick();
    drive(1'b0, 16'h0, 2'b00);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h3) begin
      n_err++;
      $display("FAIL bp_third: valid=%b data=%h want 1/00000003", out_valid, out_data);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      imm  = 16'($urandom);
      mode = 2'($urandom_range(0, 3));
      exp  = ref32(imm, mode);
      drive(1'b1, imm, mode);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_ready beat %0d: in_ready=%b want 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp || out_mode !== mode) begin
        n_err++;
        $display("FAIL stream_data beat %0d: valid=%b data=%h mode=%b want 1/%h/%b",
                 i, out_valid, out_data, out_mode, exp, mode);
      end
    end
    drive(1'b0, 16'h0, 2'b00);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 2'b00);
    tick();
    drive(1'b1, 16'h2222, 2'b00);
    tick();
    drive(1'b1, 16'h3333, 2'b00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 2'b00);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_full: valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_leak cycle %0d: valid=%b data=%h want 0", i, out_valid, out_data);
      end
    end
    drive(1'b1, 16'h4444, 2'b00);
    tick();
    drive(1'b0, 16'h0, 2'b00);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h00004444) begin
      n_err++;
      $display("FAIL flush_after: valid=%b data=%h want 1/00004444", out_valid, out_data);
    end
    // Flush while the consumer takes the head: block still empties.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ready: valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 2'b01);
    tick();
    drive(1'b1, 16'h5555, 2'b10);
    tick();
    drive(1'b1, 16'h1234, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 2'b00);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || out_mode !== 2'b00) begin
      n_err++;
      $display("FAIL rst_stall: valid=%b data=%h in_ready=%b mode=%b want 0/0/1/00",
               out_valid, out_data, in_ready, out_mode);
    end
    out_ready = 1'b1;
    drive(1'b1, 16'h7FFF, 2'b11);
    tick();
    drive(1'b0, 16'h0, 2'b00);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h0001FFFC || out_mode !== 2'b11) begin
      n_err++;
      $display("FAIL rst_first_beat: valid=%b data=%h mode=%b want 1/0001fffc/11",
               out_valid, out_data, out_mode);
    end
    tick();
  endtask

  task automatic test_narrow();
    logic [15:0] exp [4] = '{16'h0080, 16'hFF80, 16'h8000, 16'hFE00};
    out_ready8 = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid8 = 1'b1;
      in_imm8   = 8'h80;
      in_mode8  = 2'(m);
      tick();
      in_valid8 = 1'b0;
      n_cmp++;
      if (out_valid8 !== 1'b1 || out_data8 !== exp[m] || out_mode8 !== 2'(m)) begin
        n_err++;
        $display("FAIL narrow_mode%0d: valid=%b data=%h mode=%b want 1/%h/%0d",
                 m, out_valid8, out_data8, out_mode8, exp[m], m);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, 2'b11);
    in_valid8 = 1'b0;
    in_imm8 = 8'h00;
    in_mode8 = 2'b00;
    out_ready8 = 1'b0;
    test_reset();
    test_modes();
    test_back_pressure();
    test_streaming();
    test_flush_full();
    test_reset_stall();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
